// File: rtl/an_config_tx.sv
// an_config_tx: clause-37 style auto-negotiation transmitter producing /C1/,/C2/ config
// and /I2/ idle ordered sets one symbol per clock, with ability/ack match tracking.
module an_config_tx #(
  parameter int LINK_TIMER  = 200000,
  parameter int MATCH_COUNT = 3,
  parameter int SGMII_MODE  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] local_cfg,
  input  logic [15:0] rx_cfg,
  input  logic        rx_cfg_valid,
  output logic [7:0]  tx_data,
  output logic        tx_k,
  output logic [2:0]  an_state,
  output logic        an_done,
  output logic [15:0] partner_cfg
);
  localparam int TW = $clog2(LINK_TIMER + 1);
  localparam logic [TW-1:0] TLOAD = TW'(LINK_TIMER - 1);
  localparam logic [3:0] MC = 4'(MATCH_COUNT);
  typedef enum logic [2:0] {
    IDLE = 3'd0, AN_RESTART = 3'd1, ABILITY_DETECT = 3'd2,
    ACK_DETECT = 3'd3, COMPLETE_ACK = 3'd4, LINK_OK = 3'd5
  } state_e;
  state_e st_q, st_d;
  logic [1:0] sym_q, sym_d;
  logic alt_q, alt_d;
  logic [15:0] cfg_q, cfg_d, prev_q, prev_d, partner_q, partner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic start_q, start_d, rst_q, rst_d, abil_q, abil_d, ack_q, ack_d, mism_q, mism_d;
  logic cfg_set, bnd, entry, go_restart, tmr_done;
  logic abil_now, ack_now, mism_now, rst_now;
  logic [15:0] rx_m, abil_cfg;
  logic [3:0] cnt_inc, cnt_rx;
  assign cfg_set    = st_q inside {AN_RESTART, ABILITY_DETECT, ACK_DETECT, COMPLETE_ACK};
  assign bnd        = sym_q == (cfg_set ? 2'd3 : 2'd1);
  assign tmr_done   = tmr_q == '0;
  assign rx_m       = rx_cfg & 16'hBFFF;
  assign abil_cfg   = (local_cfg & 16'hBFFF) | {15'd0, SGMII_MODE != 0};
  assign cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  // ack phase counts only exact echoes of the latched partner word with ack set
  assign cnt_rx     = (st_q == ACK_DETECT) ? ((rx_cfg == (partner_q | 16'h4000)) ? cnt_inc : 4'd0)
                    : (rx_m != 16'h0 && rx_m == prev_q) ? cnt_inc : {3'd0, rx_m != 16'h0};
  assign abil_now   = rx_cfg_valid && st_q == ABILITY_DETECT && !abil_q && cnt_rx == MC;
  assign ack_now    = rx_cfg_valid && st_q == ACK_DETECT && cnt_rx == MC;
  assign mism_now   = rx_cfg_valid && st_q == ACK_DETECT && rx_m != (partner_q & 16'hBFFF);
  assign rst_now    = rx_cfg_valid && rx_cfg == 16'h0 && st_q inside {ACK_DETECT, COMPLETE_ACK, LINK_OK};
  assign go_restart = start || start_q || rst_now || rst_q;
  always_comb begin
    st_d = st_q;
    if (bnd) begin
      if (go_restart) st_d = AN_RESTART;
      else case (st_q)
        AN_RESTART:     if (tmr_done) st_d = ABILITY_DETECT;
        ABILITY_DETECT: if (abil_q || abil_now) st_d = ACK_DETECT;
        ACK_DETECT:     if (mism_q || mism_now) st_d = ABILITY_DETECT;
                        else if (ack_q || ack_now) st_d = COMPLETE_ACK;
        COMPLETE_ACK:   if (tmr_done) st_d = LINK_OK;
        default: ;
      endcase
    end
    entry     = bnd && (go_restart || st_d != st_q);
    sym_d     = bnd ? 2'd0 : sym_q + 2'd1;
    alt_d     = entry ? 1'b0 : (bnd && cfg_set) ? !alt_q : alt_q;
    tmr_d     = entry ? TLOAD : tmr_done ? tmr_q : tmr_q - TW'(1);
    cnt_d     = (entry || abil_now) ? 4'd0 : rx_cfg_valid ? cnt_rx : cnt_q;
    prev_d    = rx_cfg_valid ? rx_m : prev_q;
    partner_d = abil_now ? rx_cfg : partner_q;
    start_d   = !bnd && (start_q || start);
    rst_d     = !bnd && (rst_q || rst_now);
    abil_d    = !bnd && (abil_q || abil_now);
    ack_d     = !bnd && (ack_q || ack_now);
    mism_d    = !bnd && (mism_q || mism_now);
    cfg_d     = !bnd ? cfg_q : st_d == AN_RESTART ? 16'h0
              : st_d == ABILITY_DETECT ? abil_cfg : abil_cfg | 16'h4000;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= IDLE;
      sym_q     <= 2'd0;
      alt_q     <= 1'b0;
      cfg_q     <= 16'h0;
      prev_q    <= 16'h0;
      partner_q <= 16'h0;
      cnt_q     <= 4'd0;
      tmr_q     <= '0;
      start_q   <= 1'b0;
      rst_q     <= 1'b0;
      abil_q    <= 1'b0;
      ack_q     <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      sym_q     <= sym_d;
      alt_q     <= alt_d;
      cfg_q     <= cfg_d;
      prev_q    <= prev_d;
      partner_q <= partner_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      start_q   <= start_d;
      rst_q     <= rst_d;
      abil_q    <= abil_d;
      ack_q     <= ack_d;
      mism_q    <= mism_d;
    end
  end
  assign tx_k        = sym_q == 2'd0;
  assign tx_data     = sym_q == 2'd0 ? 8'hBC
                     : sym_q == 2'd1 ? (!cfg_set ? 8'h50 : alt_q ? 8'h42 : 8'hB5)
                     : sym_q == 2'd2 ? cfg_q[7:0] : cfg_q[15:8];
  assign an_state    = st_q;
  assign an_done     = st_q == LINK_OK;
  assign partner_cfg = partner_q;
endmodule

// File: tb/tb_an_config_tx.sv
// tb_an_config_tx: directed per-cycle symbol/state vectors through a full negotiation,
// followed by a hand-written mid-set asynchronous reset sequence.
module tb_an_config_tx;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, rx_cfg_valid = 1'b0;
  logic [15:0] local_cfg = 16'h0, rx_cfg = 16'h0;
  logic [7:0] tx_data;
  logic tx_k, an_done;
  logic [2:0] an_state;
  logic [15:0] partner_cfg;
  int checks = 0, errors = 0;
  typedef struct {
    logic st; logic vld; logic [15:0] rx; logic [15:0] loc;
    logic [7:0] d; logic k; logic [2:0] s; logic done; logic [15:0] p;
  } vec_t;
  vec_t vec[80];
  int n = 0;
  an_config_tx #(.LINK_TIMER(16), .MATCH_COUNT(3), .SGMII_MODE(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .local_cfg(local_cfg),
    .rx_cfg(rx_cfg), .rx_cfg_valid(rx_cfg_valid), .tx_data(tx_data), .tx_k(tx_k),
    .an_state(an_state), .an_done(an_done), .partner_cfg(partner_cfg)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic k, input logic [2:0] s, input logic done);
    vec[n].st = 1'b0; vec[n].vld = 1'b0; vec[n].rx = 16'h0; vec[n].loc = 16'h0;
    vec[n].d = d; vec[n].k = k; vec[n].s = s; vec[n].done = done; vec[n].p = 16'h0;
    n++;
  endtask
  task automatic add_i(input logic [2:0] s, input logic done);
    push(8'hBC, 1'b1, s, done);
    push(8'h50, 1'b0, s, done);
  endtask
  task automatic add_c(input logic alt, input logic [15:0] cfg, input logic [2:0] s);
    push(8'hBC, 1'b1, s, 1'b0);
    push(alt ? 8'h42 : 8'hB5, 1'b0, s, 1'b0);
    push(cfg[7:0], 1'b0, s, 1'b0);
    push(cfg[15:8], 1'b0, s, 1'b0);
  endtask
  task automatic rxv(input int i, input logic [15:0] rx);
    vec[i].vld = 1'b1;
    vec[i].rx  = rx;
  endtask
  initial begin
    add_i(3'd0, 1'b0); add_i(3'd0, 1'b0);
    add_c(1'b0, 16'h0000, 3'd1); add_c(1'b1, 16'h0000, 3'd1);
    add_c(1'b0, 16'h0000, 3'd1); add_c(1'b1, 16'h0000, 3'd1);
    add_c(1'b0, 16'h0001, 3'd2);
    add_c(1'b0, 16'h4001, 3'd3);
    add_c(1'b0, 16'h0001, 3'd2);
    add_c(1'b0, 16'h4001, 3'd3);
    add_c(1'b0, 16'h4001, 3'd4); add_c(1'b1, 16'h4001, 3'd4);
    add_c(1'b0, 16'h4001, 3'd4); add_c(1'b1, 16'h4001, 3'd4);
    add_i(3'd5, 1'b1); add_i(3'd5, 1'b1);
    add_c(1'b0, 16'h0000, 3'd1); add_c(1'b1, 16'h0000, 3'd1);
    add_c(1'b0, 16'h0000, 3'd1); add_c(1'b1, 16'h0000, 3'd1);
    add_c(1'b0, 16'h01A1, 3'd2);
    for (int i = 0; i < n; i++) begin
      vec[i].p   = i < 23 ? 16'h0000 : i < 31 ? 16'h4001 : 16'h0001;
      vec[i].loc = i < 28 ? 16'h0000 : i < 56 ? 16'h4001 : 16'h41A0;
    end
    vec[2].st = 1'b1;
    rxv(20, 16'h4001); rxv(21, 16'h4001); rxv(22, 16'h4001); rxv(23, 16'hD801);
    rxv(25, 16'h0021);
    rxv(28, 16'h0001); rxv(29, 16'h0001); rxv(30, 16'h0001);
    rxv(32, 16'h4001); rxv(33, 16'h4001); rxv(34, 16'h4001);
    rxv(53, 16'h4001);
    rxv(55, 16'h0000); vec[55].st = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_hold", {tx_data, tx_k, an_state, an_done, partner_cfg},
        {8'hBC, 1'b1, 3'd0, 1'b0, 16'h0000});
    reset_n = 1'b1;
    for (int i = 0; i < n - 2; i++) begin
      chk($sformatf("cyc%0d", i), {tx_data, tx_k, an_state, an_done, partner_cfg},
          {vec[i].d, vec[i].k, vec[i].s, vec[i].done, vec[i].p});
      start = vec[i].st; rx_cfg_valid = vec[i].vld; rx_cfg = vec[i].rx; local_cfg = vec[i].loc;
      @(negedge clock);
    end
    start = 1'b0; rx_cfg_valid = 1'b0; rx_cfg = 16'h0;
    chk("c1_sym2_before_reset", {tx_data, tx_k, an_state}, {8'hA1, 1'b0, 3'd2});
    reset_n = 1'b0;
    #1;
    chk("async_reset", {tx_data, tx_k, an_state, an_done, partner_cfg},
        {8'hBC, 1'b1, 3'd0, 1'b0, 16'h0000});
    @(posedge clock);
    #1;
    chk("reset_held_edge", {tx_data, tx_k, an_state}, {8'hBC, 1'b1, 3'd0});
    @(negedge clock);
    reset_n = 1'b1;
    chk("post_reset_sym0", {tx_data, tx_k, an_state}, {8'hBC, 1'b1, 3'd0});
    @(negedge clock);
    chk("post_reset_sym1", {tx_data, tx_k, an_state}, {8'h50, 1'b0, 3'd0});
    @(negedge clock);
    chk("post_reset_sym2", {tx_data, tx_k, an_state}, {8'hBC, 1'b1, 3'd0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/an_config_tx.md
AN_CONFIG_TX -- requirements
Module: an_config_tx

Interface
REQ-001 The block SHALL have parameter LINK_TIMER, default 200000, meaning link-timer length in clock cycles (1.6 ms at 125 MHz); legal range 4 or more.
REQ-002 The block SHALL have parameter MATCH_COUNT, default 3, meaning consecutive identical partner configs needed for ability/ack match; legal range 1 to 15.
REQ-003 The block SHALL have parameter SGMII_MODE, default 1, meaning 1 = SGMII (transmitted cfg bit 0 forced 1), 0 = 1000BASE-X (cfg sent as given).
REQ-004 The block SHALL have port clock, input, width 1, the 125 MHz symbol clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, width 1, an asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, width 1, a one-cycle pulse that (re)starts auto-negotiation.
REQ-007 The block SHALL have port local_cfg, input, width 16, the local ability word; bit 14 (ack) is ignored and driven by the block.
REQ-008 The block SHALL have port rx_cfg, input, width 16, the partner config word, valid with rx_cfg_valid.
REQ-009 The block SHALL have port rx_cfg_valid, input, width 1, a one-cycle pulse per received /C1/ or /C2/ ordered set.
REQ-010 The block SHALL have port tx_data, output, width 8, the transmit symbol (8b, pre-encoding).
REQ-011 The block SHALL have port tx_k, output, width 1, asserted when tx_data is a K character.
REQ-012 The block SHALL have port an_state, output, width 3, the current state encoding per REQ-016.
REQ-013 The block SHALL have port an_done, output, width 1, held high while in LINK_OK.
REQ-014 The block SHALL have port partner_cfg, output, width 16, the last matched partner word.

Function
REQ-015 The block SHALL emit one symbol per clock: /C1/ = BC(k) B5 cfg[7:0] cfg[15:8]; /C2/ = BC(k) 42 cfg[7:0] cfg[15:8]; /I2/ = BC(k) 50; only symbol 0 of each set has tx_k=1.
REQ-016 The block SHALL implement states IDLE=0, AN_RESTART=1, ABILITY_DETECT=2, ACK_DETECT=3, COMPLETE_ACK=4, LINK_OK=5.
REQ-017 In config-sending states the block SHALL alternate /C1/,/C2/ starting with /C1/ on state entry.
REQ-018 The block SHALL change state and sample cfg contents only at an ordered-set boundary (after the last symbol of the current set), so no set is ever truncated.
REQ-019 In IDLE and LINK_OK the block SHALL send /I2/ continuously.
REQ-020 On start, the block SHALL go from any state to AN_RESTART at the next set boundary.
REQ-021 In AN_RESTART the block SHALL send cfg=0000 until the link timer expires (LINK_TIMER cycles from entry), then go to ABILITY_DETECT.
REQ-022 In ABILITY_DETECT the block SHALL send tx_cfg = local_cfg with bit14=0, with bit0=1 if SGMII_MODE.
REQ-023 The block SHALL maintain a match counter that increments when rx_cfg (bit 14 masked) equals the previous rx_cfg (bit 14 masked) and is nonzero; otherwise the counter is set to 1 (nonzero) or 0 (zero word).
REQ-024 When the counter reaches MATCH_COUNT in ABILITY_DETECT, the block SHALL latch partner_cfg, clear the counter, and go to ACK_DETECT.
REQ-025 In ACK_DETECT the block SHALL send tx_cfg with bit14=1; MATCH_COUNT consecutive rx_cfg equal to partner_cfg with bit14=1 SHALL go to COMPLETE_ACK.
REQ-026 In ACK_DETECT, an rx_cfg differing from partner_cfg in bits other than bit 14 SHALL return the block to ABILITY_DETECT.
REQ-027 In COMPLETE_ACK the block SHALL continue sending ack for LINK_TIMER cycles, then go to LINK_OK.
REQ-028 In ACK_DETECT, COMPLETE_ACK or LINK_OK, an rx_cfg_valid with rx_cfg==0000 SHALL force AN_RESTART (partner restart).
REQ-029 If start and a restart condition coincide, the result SHALL be a single AN_RESTART entry with the timer reloaded.
REQ-030 The link timer SHALL be $clog2(LINK_TIMER+1) bits wide, load on state entry, and saturate at 0.
REQ-031 The match counter SHALL be 4 bits wide and saturate.
REQ-032 In LINK_OK, rx_cfg_valid with a nonzero word SHALL be ignored.

Reset
REQ-033 While reset_n is low the block SHALL drive state IDLE, tx_data=BC, tx_k=1, an_done=0, partner_cfg=0000, and counters=0; on release the first symbol is BC(k), then 50.
REQ-034 Reset asserted mid-set SHALL take effect immediately (asynchronously) and drop the remainder of the set.

Verification (LINK_TIMER=16, MATCH_COUNT=3, SGMII_MODE=1)
REQ-035 Scenario: reset release with no start -> BC(k),50 repeating; an_state=0.
REQ-036 Scenario: start, partner sends 4001 three times then D801 -> 16 cycles of cfg 0000 sets, then cfgs 01 00 (local_cfg 0000), then 01 40 after the third match; partner_cfg=4001.
REQ-037 Scenario: happy path with local_cfg=0001 and partner sending 0001, then 4001 x3 -> COMPLETE_ACK for 16 cycles, an_done=1, /I2/ output.
REQ-038 Scenario: in ACK_DETECT, partner sends 0021 -> returns to ABILITY_DETECT at the next boundary, ack bit cleared.
REQ-039 Scenario: in LINK_OK, rx_cfg=0000 -> AN_RESTART, an_done=0, cfg 0000 transmitted.
REQ-040 Scenario: reset_n pulsed low during symbol 2 of a /C1/ -> outputs immediately BC(k), state 0.
